data_mem_ctrl: RTL and testbench

//  Word-organised data memory with a valid/ready request port, programmable wait states and byte/half/word access.

---
 rtl/data_mem_ctrl_if.sv | 23 ++
 rtl/data_mem_ctrl.sv | 156 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a pipeline MEM stage (master) and the data memory controller (slave).
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with valid/ready requests, programmable wait states,
// byte/half/word loads (signed or unsigned) and stores, and an error response for bad addresses.
module data_mem_ctrl #(
  parameter int unsigned DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic           clk,
  input logic           rst,
  data_mem_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [31:0]      mem_q [DEPTH];

  logic [31:0]      off;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic             dec_err;
  logic [31:0]      cur_word;
  logic [31:0]      shifted;
  logic [15:0]      half;
  logic [31:0]      ld_data;
  logic [31:0]      st_mask;
  logic [31:0]      st_data;
  logic [31:0]      st_word;
  logic             mem_we;

  // Decode works on the latched request so req_* may change freely after acceptance.
  always_comb begin
    off      = addr_q - BASE_ADDR;
    lane     = off[1:0];
    idx      = off[IDX_W+1:2];
    dec_err  = (addr_q < BASE_ADDR)
            || ({2'b00, off[31:2]} >= DEPTH)
            || (size_q == 2'b11)
            || ((size_q == 2'b01) && lane[0])
            || ((size_q == 2'b10) && (lane != 2'b00));
    cur_word = mem_q[idx];
    shifted  = cur_word >> {lane, 3'b000};
    half     = lane[1] ? cur_word[31:16] : cur_word[15:0];

    case (size_q)
      2'b00:   ld_data = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ld_data = uns_q ? {16'h0, half} : {{16{half[15]}}, half};
      default: ld_data = cur_word;
    endcase

    case (size_q)
      2'b00: begin
        st_mask = 32'h0000_00FF << {lane, 3'b000};
        st_data = {24'h0, wdata_q[7:0]} << {lane, 3'b000};
      end
      2'b01: begin
        st_mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        st_data = {16'h0, wdata_q[15:0]} << {lane[1], 4'b0000};
      end
      default: begin
        st_mask = '1;
        st_data = wdata_q;
      end
    endcase
    st_word = (cur_word & ~st_mask) | (st_data & st_mask);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          err_d   = dec_err;
          rdata_d = (dec_err || write_q) ? '0 : ld_data;
          mem_we  = write_q && !dec_err;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[idx] <= st_word;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: one controller with one wait state for the access checks, one with none for throughput.
module tb_data_mem_ctrl;

  localparam int unsigned WAIT_A = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl_if a_if ();
  data_mem_ctrl_if b_if ();

  data_mem_ctrl #(.DEPTH(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  data_mem_ctrl #(.DEPTH(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction on dut_a; checks latency and that req_ready stays low while busy.
  task automatic xfer(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er);
    int  n;
    int  lat;
    logic saw_ready;
    n = 0;
    @(negedge clk);
    while (!a_if.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, {31'b0, a_if.req_ready}, 32'd1);
    a_if.req_valid    = 1'b1;
    a_if.req_write    = wr;
    a_if.req_size     = sz;
    a_if.req_unsigned = uns;
    a_if.req_addr     = addr;
    a_if.req_wdata    = wd;
    @(posedge clk);
    #1;
    a_if.req_valid = 1'b0;
    a_if.req_addr  = 32'hFFFF_FFFF;
    a_if.req_wdata = 32'h0BAD_0BAD;
    saw_ready = a_if.req_ready;
    lat = 0;
    while (!a_if.resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (a_if.req_ready) saw_ready = 1'b1;
    end
    check({tag, "_lat"}, 32'(lat), 32'(WAIT_A + 1));
    check({tag, "_busy_ready"}, {31'b0, saw_ready}, 32'd0);
    rd = a_if.resp_rdata;
    er = a_if.resp_err;
  endtask

  task automatic ld(input string tag, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                    input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    xfer(tag, 1'b0, sz, uns, addr, 32'h0, rd, er);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, {31'b0, er}, {31'b0, exp_er});
  endtask

  task automatic st(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                    input logic [31:0] wd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    xfer(tag, 1'b1, sz, 1'b0, addr, wd, rd, er);
    check({tag, "_rdata"}, rd, 32'h0);
    check({tag, "_err"}, {31'b0, er}, {31'b0, exp_er});
  endtask

  initial begin
    int  n;
    logic saw_valid;
    a_if.req_valid = 1'b0; a_if.req_write = 1'b0; a_if.req_size = 2'b10;
    a_if.req_unsigned = 1'b0; a_if.req_addr = 32'd1024; a_if.req_wdata = '0;
    b_if.req_valid = 1'b0; b_if.req_write = 1'b0; b_if.req_size = 2'b10;
    b_if.req_unsigned = 1'b0; b_if.req_addr = 32'd1024; b_if.req_wdata = '0;

    #12;
    check("rst_ready", {31'b0, a_if.req_ready}, 32'd1);
    check("rst_valid", {31'b0, a_if.resp_valid}, 32'd0);
    check("rst_rdata", a_if.resp_rdata, 32'h0);
    check("rst_err", {31'b0, a_if.resp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    ld("lw_base", 2'b10, 1'b0, 32'd1024, 32'h0, 1'b0);
    st("sw_1028", 2'b10, 32'd1028, 32'hDEADBEEF, 1'b0);
    ld("lb_1031", 2'b00, 1'b0, 32'd1031, 32'hFFFFFFDE, 1'b0);
    ld("lbu_1031", 2'b00, 1'b1, 32'd1031, 32'h000000DE, 1'b0);
    ld("lh_1030", 2'b01, 1'b0, 32'd1030, 32'hFFFFDEAD, 1'b0);
    ld("lhu_1028", 2'b01, 1'b1, 32'd1028, 32'h0000BEEF, 1'b0);
    ld("lbu_1028", 2'b00, 1'b1, 32'd1028, 32'h000000EF, 1'b0);
    st("sb_1029", 2'b00, 32'd1029, 32'hFFFFFF5A, 1'b0);
    ld("lw_after_sb", 2'b10, 1'b0, 32'd1028, 32'hDEAD5AEF, 1'b0);
    st("sh_1030", 2'b01, 32'd1030, 32'hFFFF1234, 1'b0);
    ld("lw_after_sh", 2'b10, 1'b0, 32'd1028, 32'h12345AEF, 1'b0);
    ld("lw_top", 2'b10, 1'b0, 32'd1276, 32'h0, 1'b0);

    ld("err_lw_1026", 2'b10, 1'b0, 32'd1026, 32'h0, 1'b1);
    ld("err_lh_1029", 2'b01, 1'b0, 32'd1029, 32'h0, 1'b1);
    st("err_sw_1020", 2'b10, 32'd1020, 32'h11111111, 1'b1);
    ld("err_lw_end", 2'b10, 1'b0, 32'd1280, 32'h0, 1'b1);
    st("err_sz11", 2'b11, 32'd1028, 32'h22222222, 1'b1);
    st("err_sh_1029", 2'b01, 32'd1029, 32'h3333, 1'b1);
    ld("lw_unchanged", 2'b10, 1'b0, 32'd1028, 32'h12345AEF, 1'b0);
    ld("lw_1024_clean", 2'b10, 1'b0, 32'd1024, 32'h0, 1'b0);

    // Store dropped by a reset arriving just before its commit edge.
    @(negedge clk);
    a_if.req_valid = 1'b1; a_if.req_write = 1'b1; a_if.req_size = 2'b10;
    a_if.req_addr = 32'd1032; a_if.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    a_if.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (a_if.resp_valid) saw_valid = 1'b1;
    end
    check("rstbusy_no_valid", {31'b0, saw_valid}, 32'd0);
    check("rstbusy_ready", {31'b0, a_if.req_ready}, 32'd1);
    ld("rstbusy_lw_1032", 2'b10, 1'b0, 32'd1032, 32'h0, 1'b0);

    // Zero-wait instance with req_valid held high: accept every 3rd edge, response one edge later.
    @(negedge clk);
    b_if.req_valid = 1'b1;
    b_if.req_addr  = 32'd1024;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("b2b_ready_%0d", i), {31'b0, b_if.req_ready}, {31'b0, (i % 3) == 0});
      check($sformatf("b2b_valid_%0d", i), {31'b0, b_if.resp_valid}, {31'b0, (i % 3) == 2});
      if (b_if.resp_valid) n++;
      @(negedge clk);
    end
    b_if.req_valid = 1'b0;
    check("b2b_resp_count", 32'(n), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
